// File: rtl/omem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : omem_pkg
// Brief    : Shared types and constants for the OMEM potential store.
// Revision : 1.0
// ============================================================================
package omem_pkg;

    localparam int         SUM_WIDTH             = 13;
    localparam int         DATA_WIDTH            = 25;
    localparam logic [3:0] OP_PREVIOUS_POTENTIAL = 4'd2;
    localparam logic [3:0] OMEM_ID               = 4'd12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        TSDONE = 2'd2,
        DONE   = 2'd3
    } omem_state_e;

    typedef struct packed {
        logic [2:0] pe_id;
        logic       is_req;
    } spe_opcode_t;

endpackage
`default_nettype wire

// File: rtl/omem_spike_map.sv
`default_nettype none
// ============================================================================
// Module   : omem_spike_map
// Brief    : Double-buffered spike bitmap with swap and registered read port.
// Revision : 1.0
// ============================================================================
module omem_spike_map #(
    parameter int NPOS   = 441,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_bit,
    input  logic              swap,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data
);

    logic [NPOS-1:0] r_spk_cur;
    logic [NPOS-1:0] r_spk_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spk_cur  <= '0;
            r_spk_prev <= '0;
            rd_data    <= 1'b0;
        end else begin
            if (wr_en) begin
                r_spk_cur[wr_addr] <= wr_bit;
            end
            if (swap) begin
                r_spk_prev <= r_spk_cur;
            end
            rd_data <= (rd_addr < ADDR_W'(NPOS)) ? r_spk_prev[rd_addr] : 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/omem_potential_store.sv
`default_nettype none
// ============================================================================
// Module   : omem_potential_store
// Brief    : Per-timestep membrane potential / spike store serving SPE requests.
// Revision : 1.0
// ============================================================================
module omem_potential_store
    import omem_pkg::*;
#(
    parameter  int NUM_SPE       = 5,
    parameter  int OUTPUT_DIM    = 21,
    parameter  int NUM_TIMESTEPS = 2,
    localparam int NPOS          = OUTPUT_DIM * OUTPUT_DIM,
    localparam int ADDR_W        = $clog2(NPOS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_opcode,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [3:0]            resp_dest,
    output logic [3:0]            resp_opcode,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  ts_done,
    output logic [1:0]            ts_num,
    output logic                  all_done,
    output logic                  err,
    input  logic [ADDR_W-1:0]     spk_rd_addr,
    output logic                  spk_rd_data
);

    localparam int IDX_W = ADDR_W + 3;

    spe_opcode_t          w_op;
    omem_state_e          r_state;
    omem_state_e          w_next;
    logic [ADDR_W-1:0]    r_ptr [NUM_SPE];
    logic [ADDR_W-1:0]    r_wcount;
    logic [ADDR_W-1:0]    w_ptr_sel;
    logic [IDX_W-1:0]     w_idx;
    logic [ADDR_W-1:0]    w_addr;
    logic                 w_acc;
    logic                 w_pe_ok;
    logic                 w_idx_ok;
    logic                 w_wr;
    logic                 w_rd;
    logic [SUM_WIDTH-1:0] r_pot_mem [NPOS];
    logic [SUM_WIDTH-1:0] r_pot_q;
    logic                 r_resp_valid;
    logic                 r_resp_zero;
    logic [2:0]           r_resp_pe;
    logic [1:0]           r_ts;
    logic                 r_err;
    logic                 w_unused;

    assign w_op     = spe_opcode_t'(in_opcode);
    assign w_unused = ^in_data[DATA_WIDTH-1:SUM_WIDTH+1];

    always_comb begin
        w_ptr_sel = '0;
        for (int k = 0; k < NUM_SPE; k++) begin
            if (int'(w_op.pe_id) == k) begin
                w_ptr_sel = r_ptr[k];
            end
        end
    end

    // SPE k walks the output map in strides of NUM_SPE starting at k.
    assign w_idx    = IDX_W'(w_op.pe_id) + IDX_W'(NUM_SPE) * IDX_W'(w_ptr_sel);
    assign w_addr   = w_idx[ADDR_W-1:0];
    assign w_acc    = in_valid && (r_state == IDLE);
    assign w_pe_ok  = int'(w_op.pe_id) < NUM_SPE;
    assign w_idx_ok = w_idx < IDX_W'(NPOS);
    assign w_wr     = w_acc && !w_op.is_req && w_pe_ok && w_idx_ok;
    assign w_rd     = w_acc &&  w_op.is_req && w_pe_ok && w_idx_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        ts_done  = 1'b0;
        all_done = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_rd) begin
                    w_next = RESP;
                end else if (w_wr && (r_wcount == ADDR_W'(NPOS - 1))) begin
                    w_next = TSDONE;
                end
            end
            RESP: begin
                if (r_resp_valid && resp_ready) begin
                    w_next = IDLE;
                end
            end
            TSDONE: begin
                ts_done = 1'b1;
                w_next  = (r_ts == 2'(NUM_TIMESTEPS - 1)) ? DONE : IDLE;
            end
            DONE: begin
                all_done = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_SPE; k++) begin
                r_ptr[k] <= '0;
            end
            r_wcount     <= '0;
            r_ts         <= '0;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_zero  <= 1'b0;
            r_resp_pe    <= '0;
        end else begin
            if (w_wr) begin
                for (int k = 0; k < NUM_SPE; k++) begin
                    if (int'(w_op.pe_id) == k) begin
                        r_ptr[k] <= r_ptr[k] + 1'b1;
                    end
                end
                r_wcount <= r_wcount + 1'b1;
            end
            if (w_rd) begin
                r_resp_valid <= 1'b1;
                r_resp_pe    <= w_op.pe_id;
                r_resp_zero  <= (r_ts == 2'd0);
            end else if (r_resp_valid && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
            if (r_state == TSDONE) begin
                for (int k = 0; k < NUM_SPE; k++) begin
                    r_ptr[k] <= '0;
                end
                r_wcount <= '0;
                r_ts     <= r_ts + 2'd1;
            end
            if ((w_acc && (!w_pe_ok || !w_idx_ok)) ||
                ((r_state == RESP) && in_valid && w_op.is_req)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage carries no reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_pot_mem[w_addr] <= in_data[SUM_WIDTH:1];
        end
        if (w_rd) begin
            r_pot_q <= r_pot_mem[w_addr];
        end
    end

    omem_spike_map #(
        .NPOS   (NPOS),
        .ADDR_W (ADDR_W)
    ) u_spike_map (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr),
        .wr_addr (w_addr),
        .wr_bit  (in_data[0]),
        .swap    (r_state == TSDONE),
        .rd_addr (spk_rd_addr),
        .rd_data (spk_rd_data)
    );

    assign resp_valid  = r_resp_valid;
    assign resp_dest   = r_resp_valid ? {1'b0, r_resp_pe} : 4'd0;
    assign resp_opcode = r_resp_valid ? OP_PREVIOUS_POTENTIAL : 4'd0;
    assign resp_data   = (r_resp_valid && !r_resp_zero) ? DATA_WIDTH'(r_pot_q) : '0;
    assign ts_num      = r_ts;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_omem_potential_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_omem_potential_store
// Brief    : Randomized self-checking bench with an array-based reference model.
// Revision : 1.0
// ============================================================================
module tb_omem_potential_store;

    localparam int NSPE = 5;
    localparam int NPOS = 441;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [24:0] in_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_dest;
    logic [3:0]  resp_opcode;
    logic [24:0] resp_data;
    logic        ts_done;
    logic [1:0]  ts_num;
    logic        all_done;
    logic        err;
    logic [8:0]  spk_rd_addr;
    logic        spk_rd_data;

    always #5 clk = ~clk;

    omem_potential_store dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_data     (in_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_dest   (resp_dest),
        .resp_opcode (resp_opcode),
        .resp_data   (resp_data),
        .ts_done     (ts_done),
        .ts_num      (ts_num),
        .all_done    (all_done),
        .err         (err),
        .spk_rd_addr (spk_rd_addr),
        .spk_rd_data (spk_rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-SPE pointers, potentials/spikes per timestep.
    int          m_ptr [NSPE];
    int          m_wcnt;
    int          m_ts;
    bit          m_err;
    logic [12:0] prev_pot [NPOS];
    logic [12:0] cur_pot  [NPOS];
    bit          prev_spk [NPOS];
    bit          cur_spk  [NPOS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < NSPE; k++) m_ptr[k] = 0;
        m_wcnt = 0;
        m_ts   = 0;
        m_err  = 1'b0;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_data    = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        check_eq("rst_in_ready",    in_ready,    1);
        check_eq("rst_resp_valid",  resp_valid,  0);
        check_eq("rst_resp_dest",   resp_dest,   0);
        check_eq("rst_resp_opcode", resp_opcode, 0);
        check_eq("rst_resp_data",   resp_data,   0);
        check_eq("rst_ts_done",     ts_done,     0);
        check_eq("rst_ts_num",      ts_num,      0);
        check_eq("rst_all_done",    all_done,    0);
        check_eq("rst_err",         err,         0);
        check_eq("rst_spk_rd",      spk_rd_data, 0);
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) check_eq("in_ready_timeout", in_ready, 1);
    endtask

    task automatic drive(input int k, input bit req, input logic [24:0] d);
        logic [2:0] pe;
        pe = 3'(k);
        wait_ready();
        in_valid  = 1'b1;
        in_opcode = {pe, req};
        in_data   = d;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_data   = '0;
    endtask

    task automatic send_write(input int k, input logic [12:0] pot, input bit spk);
        int idx = 0;
        bit ok  = (k < NSPE);
        bit full = 1'b0;
        if (ok) begin
            idx = k + NSPE * m_ptr[k];
            if (idx >= NPOS) ok = 1'b0;
        end
        if (!ok) begin
            m_err = 1'b1;
        end else begin
            cur_pot[idx] = pot;
            cur_spk[idx] = spk;
            m_ptr[k]++;
            m_wcnt++;
            full = (m_wcnt == NPOS);
        end
        drive(k, 1'b0, {11'($urandom), pot, spk});
        check_eq("wr_ts_done", ts_done, full);
        check_eq("wr_err", err, m_err);
        if (full) begin
            prev_pot = cur_pot;
            prev_spk = cur_spk;
            for (int j = 0; j < NSPE; j++) m_ptr[j] = 0;
            m_wcnt = 0;
            m_ts++;
            check_eq("tsdone_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            check_eq("ts_num", ts_num, m_ts);
            check_eq("ts_done_pulse", ts_done, 0);
            check_eq("all_done", all_done, (m_ts == 2));
            check_eq("post_ts_in_ready", in_ready, (m_ts < 2));
        end
    endtask

    task automatic send_request(input int k, input int hold);
        int idx = 0;
        bit ok  = (k < NSPE);
        logic [12:0] exp_d;
        if (ok) begin
            idx = k + NSPE * m_ptr[k];
            if (idx >= NPOS) ok = 1'b0;
        end
        exp_d = (ok && m_ts != 0) ? prev_pot[idx] : 13'd0;
        if (!ok) m_err = 1'b1;
        resp_ready = (hold == 0);
        drive(k, 1'b1, 25'($urandom));
        if (!ok) begin
            check_eq("bad_req_no_resp", resp_valid, 0);
            check_eq("bad_req_err",     err,        m_err);
            check_eq("bad_req_ready",   in_ready,   1);
        end else begin
            check_eq("resp_valid",  resp_valid,  1);
            check_eq("resp_dest",   resp_dest,   k);
            check_eq("resp_opcode", resp_opcode, 2);
            check_eq("resp_data",   resp_data,   exp_d);
            check_eq("resp_busy",   in_ready,    0);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check_eq("hold_valid", resp_valid, 1);
                check_eq("hold_dest",  resp_dest,  k);
                check_eq("hold_data",  resp_data,  exp_d);
                check_eq("hold_busy",  in_ready,   0);
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            check_eq("resp_taken",  resp_valid, 0);
            check_eq("resp_ready_back", in_ready, 1);
        end
        resp_ready = 1'b0;
    endtask

    task automatic check_spike(input int addr);
        spk_rd_addr = 9'(addr);
        @(posedge clk);
        #1;
        check_eq("spk_rd", spk_rd_data, prev_spk[addr]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_data = '0;
        resp_ready = 1'b0; spk_rd_addr = '0;
        apply_reset();

        // Timestep 0: first write, then a request answered with zero.
        send_write(0, 13'd40, 1'b0);
        send_request(0, 0);
        for (int idx = 1; idx < NPOS; idx++) begin
            if ($urandom_range(0, 7) == 0) send_request(idx % NSPE, $urandom_range(0, 2));
            send_write(idx % NSPE, 13'(idx % 64), idx[0]);
        end
        check_spike(7);
        check_spike(8);
        repeat (4) check_spike($urandom_range(0, NPOS - 1));

        // Timestep 1: previous-potential responses, backpressure, errors.
        send_request(2, 0);
        send_write(2, 13'($urandom), 1'($urandom));
        send_request(3, 5);
        send_write(3, 13'($urandom), 1'($urandom));
        send_request(6, 0);
        send_write(7, 13'($urandom), 1'($urandom));
        while (m_ts == 1) begin
            do k = $urandom_range(0, NSPE - 1); while (k + NSPE * m_ptr[k] >= NPOS);
            if ($urandom_range(0, 1) == 1) send_request(k, $urandom_range(0, 3));
            send_write(k, 13'($urandom), 1'($urandom));
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("done_all_done", all_done, 1);
            check_eq("done_in_ready", in_ready, 0);
        end
        repeat (6) check_spike($urandom_range(0, NPOS - 1));

        // Fresh run: reset while a response is pending.
        apply_reset();
        for (int idx = 0; idx < NPOS; idx++) send_write(idx % NSPE, 13'($urandom), 1'($urandom));
        resp_ready = 1'b0;
        drive(1, 1'b1, '0);
        check_eq("mid_resp_valid", resp_valid, 1);
        check_eq("mid_resp_data", resp_data, prev_pot[1]);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_resp_valid", resp_valid, 0);
        check_eq("rst_mid_ts_num", ts_num, 0);
        check_eq("rst_mid_in_ready", in_ready, 1);
        reset = 1'b0;
        m_reset();

        // SPE0 exhausts its 89 slots, then overruns.
        for (int i = 0; i < 89; i++) send_write(0, 13'($urandom), 1'($urandom));
        send_request(0, 0);
        send_write(0, 13'($urandom), 1'($urandom));
        send_request(1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
